// File: rtl/mul4_share_ctrl.sv
// Shares one 4x4 BCD-digit multiplier between two requesters. Result is MUL_LAT+1 cycles after accept (1 for non-BCD), one op in flight;
// readies are low unless IDLE. Arbitration is fixed priority (req0 wins) unless MUL4_SHARE_RR_EN selects round-robin.
module mul4_share_ctrl #(
   parameter int MUL_LAT = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [3:0] req0_a,
   input  logic [3:0] req0_b,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [3:0] req1_a,
   input  logic [3:0] req1_b,
   output logic       resp0_valid,
   output logic       resp1_valid,
   output logic [7:0] resp_y,
   output logic       resp_err,
   output logic [3:0] mul_a,
   output logic [3:0] mul_b,
   input  logic [7:0] mul_y,
   output logic       busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam logic [3:0] CNT_LAST = 4'(MUL_LAT - 1);

   logic [1:0] state;
   logic [3:0] a_q;
   logic [3:0] b_q;
   logic [3:0] cnt;
   logic       id_q;
   logic       idle;
   logic       win1;
   logic       accept;
   logic       bad_op;
   logic [3:0] acc_a;
   logic [3:0] acc_b;

   assign idle = (state == ST_IDLE);

`ifdef MUL4_SHARE_RR_EN
   // ptr names the requester preferred on a tie; it moves to the loser on every accept
   logic ptr;

   assign win1 = req1_valid & (~req0_valid | ptr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= 1'b0;
      end else if (accept) begin
         ptr <= ~win1;
      end
   end
`else
   assign win1 = req1_valid & ~req0_valid;
`endif

   assign req0_ready = idle & req0_valid & ~win1;
   assign req1_ready = idle & win1;
   assign accept     = req0_ready | req1_ready;
   assign acc_a      = win1 ? req1_a : req0_a;
   assign acc_b      = win1 ? req1_b : req0_b;
   assign bad_op     = (acc_a > 4'd9) || (acc_b > 4'd9);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         a_q      <= 4'd0;
         b_q      <= 4'd0;
         id_q     <= 1'b0;
         cnt      <= 4'd0;
         resp_y   <= 8'd0;
         resp_err <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  a_q  <= acc_a;
                  b_q  <= acc_b;
                  id_q <= win1;
                  cnt  <= 4'd0;
                  // non-BCD operands never reach the multiplier
                  if (bad_op) begin
                     resp_y   <= 8'd0;
                     resp_err <= 1'b1;
                     state    <= ST_DONE;
                  end else begin
                     state    <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               cnt <= cnt + 4'd1;
               if (cnt == CNT_LAST) begin
                  resp_y   <= mul_y;
                  resp_err <= 1'b0;
                  state    <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign mul_a       = (state == ST_RUN) ? a_q : 4'd0;
   assign mul_b       = (state == ST_RUN) ? b_q : 4'd0;
   assign resp0_valid = (state == ST_DONE) & ~id_q;
   assign resp1_valid = (state == ST_DONE) & id_q;
   assign busy        = ~idle;

endmodule

// File: tb/tb_mul4_share_ctrl.sv
// Bench for mul4_share_ctrl: directed and random requests against a cycle-level transaction model.
module tb_mul4_share_ctrl;

   localparam int LAT    = 3;
   localparam int M_DIR  = 0;
   localparam int M_CONT = 1;
   localparam int M_RAND = 2;

   logic       clk;
   logic       rst_n;
   logic       req0_valid;
   logic       req0_ready;
   logic [3:0] req0_a;
   logic [3:0] req0_b;
   logic       req1_valid;
   logic       req1_ready;
   logic [3:0] req1_a;
   logic [3:0] req1_b;
   logic       resp0_valid;
   logic       resp1_valid;
   logic [7:0] resp_y;
   logic       resp_err;
   logic [3:0] mul_a;
   logic [3:0] mul_b;
   logic [7:0] mul_y;
   logic       busy;

   mul4_share_ctrl #(.MUL_LAT(LAT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .resp0_valid (resp0_valid),
      .resp1_valid (resp1_valid),
      .resp_y      (resp_y),
      .resp_err    (resp_err),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_y       (mul_y),
      .busy        (busy)
   );

   // ideal combinational multiplier
   assign mul_y = {4'd0, mul_a} * {4'd0, mul_b};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int mode  = M_DIR;

   // transaction-level model: one op at a time, identified by accept and response cycle numbers
   int cyc     = 0;
   int free_at = 0;
   int acc_cyc = 0;
   int rsp_cyc = 0;
   int p_a     = 0;
   int p_b     = 0;
   int e_y     = 0;
   bit have_op = 0;
   bit p_id    = 0;
   bit p_err   = 0;
   bit e_err   = 0;
   bit ptr     = 0;
   bit g0      = 0;
   bit g1      = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [3:0] rnd_digit();
      if ($urandom_range(0, 3) == 0) return 4'($urandom_range(10, 15));
      return 4'($urandom_range(0, 9));
   endfunction

   task automatic check_zero(input string tag);
      check({tag, ".req0_ready"}, 32'(req0_ready), 0);
      check({tag, ".req1_ready"}, 32'(req1_ready), 0);
      check({tag, ".resp0_valid"}, 32'(resp0_valid), 0);
      check({tag, ".resp1_valid"}, 32'(resp1_valid), 0);
      check({tag, ".resp_y"}, 32'(resp_y), 0);
      check({tag, ".resp_err"}, 32'(resp_err), 0);
      check({tag, ".mul_a"}, 32'(mul_a), 0);
      check({tag, ".mul_b"}, 32'(mul_b), 0);
      check({tag, ".busy"}, 32'(busy), 0);
   endtask

   task automatic model_check();
      bit idle;
      int ea;
      int eb;
      idle = (cyc >= free_at);
      ea = 0;
      eb = 0;
      if (have_op && !p_err && cyc > acc_cyc && cyc < rsp_cyc) begin
         ea = p_a;
         eb = p_b;
      end
      if (have_op && cyc == rsp_cyc) begin
         e_y   = p_err ? 0 : p_a * p_b;
         e_err = p_err;
      end
      g0 = 0;
      g1 = 0;
      if (idle) begin
         if (req0_valid && req1_valid) begin
`ifdef MUL4_SHARE_RR_EN
            g1 = ptr;
            g0 = !ptr;
`else
            g0 = 1;
`endif
         end else begin
            g0 = req0_valid;
            g1 = req1_valid;
         end
      end
      check("req0_ready", 32'(req0_ready), 32'(g0));
      check("req1_ready", 32'(req1_ready), 32'(g1));
      check("busy", 32'(busy), 32'(!idle));
      check("mul_a", 32'(mul_a), ea);
      check("mul_b", 32'(mul_b), eb);
      check("resp0_valid", 32'(resp0_valid), 32'(have_op && cyc == rsp_cyc && !p_id));
      check("resp1_valid", 32'(resp1_valid), 32'(have_op && cyc == rsp_cyc && p_id));
      check("resp_y", 32'(resp_y), e_y);
      check("resp_err", 32'(resp_err), 32'(e_err));
      if (g0 || g1) begin
         have_op = 1;
         p_id    = g1;
         p_a     = g1 ? int'(req1_a) : int'(req0_a);
         p_b     = g1 ? int'(req1_b) : int'(req0_b);
         p_err   = (p_a > 9) || (p_b > 9);
         acc_cyc = cyc;
         rsp_cyc = cyc + (p_err ? 1 : 1 + LAT);
         free_at = rsp_cyc + 1;
         ptr     = g0;
      end
   endtask

   task automatic update_reqs();
      case (mode)
         M_DIR: begin
            if (g0) req0_valid = 1'b0;
            if (g1) req1_valid = 1'b0;
         end
         M_RAND: begin
            if (g0 || !req0_valid) begin
               req0_valid = 1'($urandom_range(0, 1));
               req0_a     = rnd_digit();
               req0_b     = rnd_digit();
            end
            if (g1 || !req1_valid) begin
               req1_valid = 1'($urandom_range(0, 1));
               req1_a     = rnd_digit();
               req1_b     = rnd_digit();
            end
         end
         default: begin
         end
      endcase
   endtask

   task automatic step();
      @(negedge clk);
      model_check();
      @(posedge clk);
      #1;
      cyc++;
      update_reqs();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2;
      rst_n      = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      check_zero("midrst");
      have_op = 0;
      e_y     = 0;
      e_err   = 0;
      ptr     = 0;
      g0      = 0;
      g1      = 0;
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      cyc++;
      free_at = cyc;
   endtask

   task automatic set_req0(input logic [3:0] a, input logic [3:0] b);
      req0_valid = 1'b1;
      req0_a     = a;
      req0_b     = b;
   endtask

   task automatic set_req1(input logic [3:0] a, input logic [3:0] b);
      req1_valid = 1'b1;
      req1_a     = a;
      req1_b     = b;
   endtask

   initial begin
      rst_n      = 1'b0;
      req0_valid = 1'b0;
      req0_a     = 4'd0;
      req0_b     = 4'd0;
      req1_valid = 1'b0;
      req1_a     = 4'd0;
      req1_b     = 4'd0;
      #12;
      check_zero("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      mode = M_DIR;
      set_req0(4'd7, 4'd9);
      run(7);
      set_req1(4'd12, 4'd3);
      run(4);

      // both requesters hold valid continuously
      mode = M_CONT;
      set_req0(4'd9, 4'd9);
      set_req1(4'd5, 4'd6);
      run(30);
      mode = M_DIR;
      run(12);

      set_req0(4'd8, 4'd8);
      run(7);

      // reset lands in the RUN phase of 4x4
      set_req0(4'd4, 4'd4);
      step();
      async_reset();
      set_req0(4'd2, 4'd3);
      run(8);

      mode = M_RAND;
      run(600);
      mode = M_DIR;
      run(16);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mul4_share_ctrl.md
Name: mul4_share_ctrl

Overview:
- Sequencer and arbiter that shares one 4x4 BCD-digit multiplier (4-bit operands, 8-bit binary product) between two requesters.
- Accepts one operation at a time through a valid/ready handshake.
- Drives the multiplier operands, waits a configurable settle time and captures the product.
- Returns the product to the granting requester with an error flag for non-BCD operands.
- Sits between the digit-serial BCD arithmetic front end and the shared combinational multiplier.

Parameters:
- MUL_LAT, 1: cycles operands are held on mul_a/mul_b before mul_y is sampled. Legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  4  requester 0 multiplicand digit
- req0_b  in  4  requester 0 multiplier digit
- req1_valid  in  1  requester 1 has an operation pending
- req1_ready  out  1  requester 1 operation accepted this cycle
- req1_a  in  4  requester 1 multiplicand digit
- req1_b  in  4  requester 1 multiplier digit
- resp0_valid  out  1  one-cycle pulse: result for requester 0
- resp1_valid  out  1  one-cycle pulse: result for requester 1
- resp_y  out  8  product, shared by both responses
- resp_err  out  1  operand was not a BCD digit; qualified by resp0_valid or resp1_valid
- mul_a  out  4  operand A to the multiplier
- mul_b  out  4  operand B to the multiplier
- mul_y  in  8  product from the multiplier
- busy  out  1  state is not IDLE

Behaviour:
- Reset (async, rst_n low), all effective immediately:
  - state = IDLE
  - all outputs 0
  - latched operands 0
  - cycle counter 0
  - arbitration pointer = requester 0
- Reset mid-operation aborts the operation; no response is issued for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - Winner is chosen by the arbitration policy among asserted reqN_valid.
  - Winner's reqN_ready is combinational: state==IDLE & winner. The loser's ready stays 0.
  - On valid&ready:
    - Latch a, b and the winner id.
    - If a>9 or b>9: next state DONE with resp_y=0 and err=1.
    - Otherwise: next state RUN, counter cleared.
- RUN:
  - mul_a/mul_b = latched operands.
  - Counter increments each cycle.
  - When counter==MUL_LAT-1: register mul_y into resp_y, err=0, next state DONE.
- DONE:
  - respN_valid=1 for the latched id for exactly one cycle, with resp_y and resp_err valid.
  - Next state IDLE.
  - No accept occurs in DONE; ready is 0.
- Outside RUN, mul_a = mul_b = 0.
- Latency from the accept edge:
  - Valid operands: response in cycle accept+1+MUL_LAT.
  - Invalid operands: response in cycle accept+1.
- Throughput: one operation per MUL_LAT+2 cycles maximum.
- Requester rules:
  - reqN_valid stays high and operands stay stable until ready.
  - A requester may hold valid across its own response; it is re-arbitrated in the next IDLE.
- resp_y and resp_err hold their last values until the next DONE.
- busy = (state != IDLE).
- Arithmetic: the product is taken unmodified from mul_y. The block performs no width extension and no correction.

Optional Feature:
- Macro MUL4_SHARE_RR_EN.
- When defined, arbitration is round-robin:
  - A 1-bit pointer names the preferred requester.
  - On each accept, the pointer becomes the non-granted requester.
  - With a single requester valid, that requester wins regardless of the pointer.
- When undefined, arbitration is fixed priority: requester 0 always wins a tie, and the pointer logic is absent.

Test Plan:
- req0 a=7 b=9, MUL_LAT=1 -> req0_ready high in accept cycle; mul_a=7, mul_b=9 for 1 cycle; resp0_valid pulse 2 cycles after accept with resp_y=63, resp_err=0.
- req1 a=12 b=3 -> accepted; mul_a/mul_b stay 0; resp1_valid next cycle with resp_y=0, resp_err=1.
- Both valid continuously, operands 9x9 and 5x6, fixed priority:
  - req0 granted every operation; resp_y=81 repeatedly; req1 never ready.
  - With MUL4_SHARE_RR_EN: grants alternate 0,1,0,1; results alternate 81,30.
- MUL_LAT=3, req0 a=8 b=8 -> mul_a/mul_b=8 for exactly 3 cycles; resp_y=64 at accept+4; busy high for 4 cycles.
- rst_n pulled low during RUN of 4x4 -> outputs 0 immediately; no resp0_valid after release; next request 2x3 returns 6 normally.
